imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 and 64 are legal.
REQ-002 SHALL have parameter CNT_W, default 16, illegal-instruction counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous pipeline flush.
REQ-006 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-007 SHALL have port in_ready  output  1  block can accept an instruction.
REQ-008 SHALL have port in_inst  input  32  raw RISC-V instruction.
REQ-009 SHALL have port in_pc  input  XLEN  instruction address, passed through unchanged.
REQ-010 SHALL have port out_valid  output  1  decoded result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port out_imm  output  XLEN  sign-extended immediate.
REQ-013 SHALL have port out_fmt  output  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal.
REQ-014 SHALL have port out_illegal  output  1  unsupported opcode or inst[1:0]!=2'b11.
REQ-015 SHALL have port out_pc  output  XLEN  PC of the entry on out_imm.
REQ-016 SHALL have port ill_cnt  output  CNT_W  saturating count of illegal results delivered.

Function
REQ-017 SHALL decode by opcode: I = 0000011, 0010011, 1100111 (plus 0011011 when XLEN=64) -> sext(inst[31:20]).
REQ-018 SHALL decode S = 0100011 -> sext({inst[31:25],inst[11:7]}).
REQ-019 SHALL decode B = 1100011 -> sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
REQ-020 SHALL decode U = 0110111, 0010111 -> sext({inst[31:12],12'b0}) to XLEN.
REQ-021 SHALL decode J = 1101111 -> sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
REQ-022 SHALL decode R = 0110011 (plus 0111011 when XLEN=64) -> imm 0, fmt 0.
REQ-023 SHALL treat any other opcode, or inst[1:0]!=2'b11, as illegal: imm 0, fmt 7, out_illegal 1.
REQ-024 SHALL sign-extend using inst[31] in every format, for both XLEN values.
REQ-025 SHALL accept input when in_valid && in_ready, and register the decoded result.
REQ-026 SHALL present an accepted result on out_* exactly 1 cycle after acceptance when the output stage is empty or draining.
REQ-027 SHALL sustain 1 result/cycle while out_ready is held high.
REQ-028 SHALL implement a 2-entry skid buffer (main, skid); in_ready = !skid_valid, driven from a register with no combinational path from out_ready.
REQ-029 SHALL write an input to skid when main is valid and not draining; in_ready SHALL go 0 the next cycle.
REQ-030 SHALL move skid to main on an output handshake while skid is valid, in the same edge.
REQ-031 SHALL preserve order, with no loss or duplication under any in_valid/out_ready pattern.
REQ-032 SHALL hold out_* stable while out_valid && !out_ready.
REQ-033 SHALL, on flush, invalidate main and skid at the next edge and discard any input presented that cycle; flush SHALL take priority over all handshakes.
REQ-034 SHALL increment ill_cnt on each output handshake with out_illegal=1, saturate at all-ones, and leave it unaffected by flush.

Reset
REQ-035 SHALL, while rst_n=0, asynchronously force out_valid 0, skid_valid 0, out_imm 0, out_fmt 0, out_illegal 0, out_pc 0, and ill_cnt 0.
REQ-036 SHALL drive in_ready 1 from the first edge after rst_n deasserts.
REQ-037 SHALL, on reset mid-stall, drop all buffered entries with no output handshake afterward.

Verification
REQ-038 SHALL cover: XLEN=32, in_inst 0xFFC12083 (lw) -> next cycle out_imm 0xFFFFFFFC, fmt 1; in_inst 0xFE112E23 (sw) -> 0xFFFFFFFC, fmt 2.
REQ-039 SHALL cover: in_inst 0xFE000CE3 (beq -8) -> 0xFFFFFFF8, fmt 3; in_inst 0x0010006F (jal +2048) -> 0x00000800, fmt 5.
REQ-040 SHALL cover: XLEN=64, in_inst 0x800000B7 (lui) -> 0xFFFFFFFF80000000, fmt 4.
REQ-041 SHALL cover: out_ready=0 with 3 back-to-back inputs -> 2 buffered, in_ready 0 while the 3rd is held; out_ready=1 -> A, B, C in order, one per cycle.
REQ-042 SHALL cover: in_inst 0x00000000 -> out_illegal 1, fmt 7, imm 0, ill_cnt +1 on handshake; CNT_W=2 saturates at 3.
REQ-043 SHALL cover: flush with both entries full and out_ready=0 -> out_valid 0 and in_ready 1 next cycle, ill_cnt unchanged; rst_n low mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator behind a two-entry skid buffer.
// Decodes an instruction into a sign-extended immediate and a format tag,
// registers it and hands it downstream over a valid/ready handshake.
// in_ready is a flop, so out_ready never reaches the upstream side
// through logic. Illegal results handed downstream are counted with
// saturation.
// XLEN is meant to be 32 or 64 only.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [XLEN-1:0]  out_pc,
  output logic [CNT_W-1:0] ill_cnt
);

  typedef enum logic [2:0] {
    FmtR   = 3'd0,
    FmtI   = 3'd1,
    FmtS   = 3'd2,
    FmtB   = 3'd3,
    FmtU   = 3'd4,
    FmtJ   = 3'd5,
    FmtIll = 3'd7
  } fmt_e;

  // The W-suffixed opcodes (addiw, addw, ...) only exist on RV64.
  localparam bit Rv64 = (XLEN == 64);

  logic [6:0]      opcode;
  logic [XLEN-1:0] decImm;
  fmt_e            decFmt;
  logic            decIll;

  logic            mainValid_q, mainValid_d;
  logic [XLEN-1:0] mainImm_q, mainImm_d;
  fmt_e            mainFmt_q, mainFmt_d;
  logic            mainIll_q, mainIll_d;
  logic [XLEN-1:0] mainPc_q, mainPc_d;

  logic            skidValid_q, skidValid_d;
  logic [XLEN-1:0] skidImm_q, skidImm_d;
  fmt_e            skidFmt_q, skidFmt_d;
  logic            skidIll_q, skidIll_d;
  logic [XLEN-1:0] skidPc_q, skidPc_d;

  logic             inReady_q, inReady_d;
  logic [CNT_W-1:0] illCnt_q, illCnt_d;

  logic outFire;
  logic inFire;

  // Decode the incoming instruction: fill with inst[31], then overlay the format's low bits
  always_comb begin
    opcode = in_inst[6:0];
    decImm = '0;
    decFmt = FmtIll;
    decIll = 1'b1;
    if (in_inst[1:0] == 2'b11) begin
      if (opcode == 7'b0000011 || opcode == 7'b0010011 || opcode == 7'b1100111 ||
          (Rv64 && opcode == 7'b0011011)) begin
        decImm        = {XLEN{in_inst[31]}};
        decImm[11:0]  = in_inst[31:20];
        decFmt        = FmtI;
        decIll        = 1'b0;
      end else if (opcode == 7'b0100011) begin
        decImm        = {XLEN{in_inst[31]}};
        decImm[11:0]  = {in_inst[31:25], in_inst[11:7]};
        decFmt        = FmtS;
        decIll        = 1'b0;
      end else if (opcode == 7'b1100011) begin
        decImm        = {XLEN{in_inst[31]}};
        decImm[12:0]  = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
        decFmt        = FmtB;
        decIll        = 1'b0;
      end else if (opcode == 7'b0110111 || opcode == 7'b0010111) begin
        decImm        = {XLEN{in_inst[31]}};
        decImm[31:0]  = {in_inst[31:12], 12'b0};
        decFmt        = FmtU;
        decIll        = 1'b0;
      end else if (opcode == 7'b1101111) begin
        decImm        = {XLEN{in_inst[31]}};
        decImm[20:0]  = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
        decFmt        = FmtJ;
        decIll        = 1'b0;
      end else if (opcode == 7'b0110011 || (Rv64 && opcode == 7'b0111011)) begin
        decImm        = '0;
        decFmt        = FmtR;
        decIll        = 1'b0;
      end
    end
  end

  assign outFire = mainValid_q && out_ready;
  assign inFire  = in_valid && inReady_q;

  // Buffer control: flush wins, then a skid entry refills main, else new input goes to main or skid
  always_comb begin
    mainValid_d = mainValid_q;
    mainImm_d   = mainImm_q;
    mainFmt_d   = mainFmt_q;
    mainIll_d   = mainIll_q;
    mainPc_d    = mainPc_q;
    skidValid_d = skidValid_q;
    skidImm_d   = skidImm_q;
    skidFmt_d   = skidFmt_q;
    skidIll_d   = skidIll_q;
    skidPc_d    = skidPc_q;
    illCnt_d    = illCnt_q;

    if (flush) begin
      mainValid_d = 1'b0;
      skidValid_d = 1'b0;
    end else if (skidValid_q) begin
      if (outFire) begin
        mainValid_d = 1'b1;
        mainImm_d   = skidImm_q;
        mainFmt_d   = skidFmt_q;
        mainIll_d   = skidIll_q;
        mainPc_d    = skidPc_q;
        skidValid_d = 1'b0;
      end
    end else if (inFire) begin
      if (!mainValid_q || outFire) begin
        mainValid_d = 1'b1;
        mainImm_d   = decImm;
        mainFmt_d   = decFmt;
        mainIll_d   = decIll;
        mainPc_d    = in_pc;
      end else begin
        skidValid_d = 1'b1;
        skidImm_d   = decImm;
        skidFmt_d   = decFmt;
        skidIll_d   = decIll;
        skidPc_d    = in_pc;
      end
    end else if (outFire) begin
      mainValid_d = 1'b0;
    end

    if (!flush && outFire && mainIll_q && (illCnt_q != {CNT_W{1'b1}})) begin
      illCnt_d = illCnt_q + CNT_W'(1);
    end

    inReady_d = !skidValid_d;
  end

  // State registers; ready stays low during reset and rises on the first edge after it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mainValid_q <= 1'b0;
      mainImm_q   <= '0;
      mainFmt_q   <= FmtR;
      mainIll_q   <= 1'b0;
      mainPc_q    <= '0;
      skidValid_q <= 1'b0;
      skidImm_q   <= '0;
      skidFmt_q   <= FmtR;
      skidIll_q   <= 1'b0;
      skidPc_q    <= '0;
      inReady_q   <= 1'b0;
      illCnt_q    <= '0;
    end else begin
      mainValid_q <= mainValid_d;
      mainImm_q   <= mainImm_d;
      mainFmt_q   <= mainFmt_d;
      mainIll_q   <= mainIll_d;
      mainPc_q    <= mainPc_d;
      skidValid_q <= skidValid_d;
      skidImm_q   <= skidImm_d;
      skidFmt_q   <= skidFmt_d;
      skidIll_q   <= skidIll_d;
      skidPc_q    <= skidPc_d;
      inReady_q   <= inReady_d;
      illCnt_q    <= illCnt_d;
    end
  end

  assign in_ready    = inReady_q;
  assign out_valid   = mainValid_q;
  assign out_imm     = mainImm_q;
  assign out_fmt     = mainFmt_q;
  assign out_illegal = mainIll_q;
  assign out_pc      = mainPc_q;
  assign ill_cnt     = illCnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: an RV32 instance and an RV64 instance
// with a 2-bit illegal counter share one stimulus stream.
module tb_imm_gen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] pc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        inValid;
  logic [31:0] inInst;
  logic [63:0] inPc64;
  logic        outReady;

  logic        inReady32, outValid32, outIllegal32;
  logic [31:0] outImm32, outPc32;
  logic [2:0]  outFmt32;
  logic [15:0] illCnt32;

  logic        inReady64, outValid64, outIllegal64;
  logic [63:0] outImm64, outPc64;
  logic [2:0]  outFmt64;
  logic [1:0]  illCnt64;

  exp_t q32[$];
  exp_t q64[$];
  exp_t m32, m64;

  int checks = 0;
  int errors = 0;
  int hs32 = 0;
  int hs64 = 0;

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(inValid), .in_ready(inReady32), .in_inst(inInst), .in_pc(inPc64[31:0]),
    .out_valid(outValid32), .out_ready(outReady), .out_imm(outImm32), .out_fmt(outFmt32),
    .out_illegal(outIllegal32), .out_pc(outPc32), .ill_cnt(illCnt32)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(inValid), .in_ready(inReady64), .in_inst(inInst), .in_pc(inPc64),
    .out_valid(outValid64), .out_ready(outReady), .out_imm(outImm64), .out_fmt(outFmt64),
    .out_illegal(outIllegal64), .out_pc(outPc64), .ill_cnt(illCnt64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
    exp_t e;
    e.imm = imm;
    e.fmt = fmt;
    e.ill = ill;
    e.pc  = '0;
    return e;
  endfunction

  // Present one instruction for one cycle; push expectations if it will be accepted
  task automatic presentCycle(input logic [31:0] inst, input logic [63:0] pc,
                              input exp_t e32, input exp_t e64, output bit acc);
    @(posedge clk);
    #1;
    inValid = 1'b1;
    inInst  = inst;
    inPc64  = pc;
    @(negedge clk);
    acc = inReady32 && rst_n && !flush;
    if (acc) begin
      e32.pc = {32'h0, pc[31:0]};
      e64.pc = pc;
      q32.push_back(e32);
      q64.push_back(e64);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] inst, input logic [63:0] pc,
                               input exp_t e32, input exp_t e64);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) presentCycle(inst, pc, e32, e64, acc);
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: inst %h never accepted", inst);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    outReady = 1'b1;
    idle();
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (!outValid32 && !outValid64) done = 1'b1;
    end
    #1;
    checkOutput("drain", {63'h0, done}, 64'h1);
  endtask

  // Monitor: compare the head of each queue whenever a result is shown, pop on handshake
  always @(negedge clk) begin
    if (rst_n && !flush) begin
      if (outValid32) begin
        if (q32.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected32: got out_valid 1 required 0");
        end else begin
          m32 = q32[0];
          checkOutput("imm32", {32'h0, outImm32}, {32'h0, m32.imm[31:0]});
          checkOutput("fmt32", {61'h0, outFmt32}, {61'h0, m32.fmt});
          checkOutput("ill32", {63'h0, outIllegal32}, {63'h0, m32.ill});
          checkOutput("pc32", {32'h0, outPc32}, m32.pc);
          if (outReady) begin
            m32 = q32.pop_front();
            hs32++;
          end
        end
      end
      if (outValid64) begin
        if (q64.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected64: got out_valid 1 required 0");
        end else begin
          m64 = q64[0];
          checkOutput("imm64", outImm64, m64.imm);
          checkOutput("fmt64", {61'h0, outFmt64}, {61'h0, m64.fmt});
          checkOutput("ill64", {63'h0, outIllegal64}, {63'h0, m64.ill});
          checkOutput("pc64", outPc64, m64.pc);
          if (outReady) begin
            m64 = q64.pop_front();
            hs64++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t eIll, eAll1;
    bit acc;
    int base32, base64;
    eIll  = mk(64'h0, 3'd7, 1'b1);
    eAll1 = mk(64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    rst_n = 1'b0; flush = 1'b0; inValid = 1'b0; inInst = '0; inPc64 = '0; outReady = 1'b1;

    // Reset state
    @(posedge clk);
    #1;
    checkOutput("rst_valid32", {63'h0, outValid32}, 64'h0);
    checkOutput("rst_valid64", {63'h0, outValid64}, 64'h0);
    checkOutput("rst_ready32", {63'h0, inReady32}, 64'h0);
    checkOutput("rst_imm64", outImm64, 64'h0);
    checkOutput("rst_fmt32", {61'h0, outFmt32}, 64'h0);
    checkOutput("rst_ill64", {63'h0, outIllegal64}, 64'h0);
    checkOutput("rst_pc64", outPc64, 64'h0);
    checkOutput("rst_cnt32", {48'h0, illCnt32}, 64'h0);
    checkOutput("rst_cnt64", {62'h0, illCnt64}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_before_edge", {63'h0, inReady32}, 64'h0);
    @(posedge clk);
    #1;
    checkOutput("ready_after_edge32", {63'h0, inReady32}, 64'h1);
    checkOutput("ready_after_edge64", {63'h0, inReady64}, 64'h1);

    // Single-cycle latency from an empty pipeline
    applyStimulus(32'hFFC12083, 64'h1_8000_0000, mk(64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0),
                  mk(64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0));
    idle();
    @(negedge clk);
    #1;
    checkOutput("latency_valid32", {63'h0, outValid32}, 64'h1);
    checkOutput("latency_valid64", {63'h0, outValid64}, 64'h1);

    // Decode table, back to back with out_ready high
    applyStimulus(32'hFE112E23, 64'h1_8000_0004, mk(64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0),
                  mk(64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0));
    applyStimulus(32'hFE000CE3, 64'h1_8000_0008, mk(64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0),
                  mk(64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0));
    applyStimulus(32'h0010006F, 64'h1_8000_000C, mk(64'h800, 3'd5, 1'b0), mk(64'h800, 3'd5, 1'b0));
    applyStimulus(32'h800000B7, 64'h1_8000_0010, mk(64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0),
                  mk(64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0));
    applyStimulus(32'h12345017, 64'h1_8000_0014, mk(64'h1234_5000, 3'd4, 1'b0),
                  mk(64'h1234_5000, 3'd4, 1'b0));
    applyStimulus(32'h002081B3, 64'h1_8000_0018, mk(64'h0, 3'd0, 1'b0), mk(64'h0, 3'd0, 1'b0));
    applyStimulus(32'h7FF00093, 64'h1_8000_001C, mk(64'h7FF, 3'd1, 1'b0), mk(64'h7FF, 3'd1, 1'b0));
    applyStimulus(32'hFFF0009B, 64'h1_8000_0020, eIll, eAll1);
    applyStimulus(32'h00000000, 64'h1_8000_0024, eIll, eIll);
    applyStimulus(32'h80000067, 64'h1_8000_0028, mk(64'hFFFF_FFFF_FFFF_F800, 3'd1, 1'b0),
                  mk(64'hFFFF_FFFF_FFFF_F800, 3'd1, 1'b0));
    applyStimulus(32'h00000001, 64'h1_8000_002C, eIll, eIll);
    applyStimulus(32'h002080BB, 64'h1_8000_0030, eIll, mk(64'h0, 3'd0, 1'b0));
    applyStimulus(32'h00208463, 64'h1_8000_0034, mk(64'h8, 3'd3, 1'b0), mk(64'h8, 3'd3, 1'b0));
    applyStimulus(32'hFFDFF06F, 64'h1_8000_0038, mk(64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0),
                  mk(64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0));
    waitDrain();
    checkOutput("cnt32_after_table", {48'h0, illCnt32}, 64'd4);
    checkOutput("cnt64_after_table", {62'h0, illCnt64}, 64'd2);

    // Illegal counter increments, 2-bit counter saturates at 3
    applyStimulus(32'h00000000, 64'h1_8000_0040, eIll, eIll);
    waitDrain();
    checkOutput("cnt32_inc", {48'h0, illCnt32}, 64'd5);
    checkOutput("cnt64_inc", {62'h0, illCnt64}, 64'd3);
    applyStimulus(32'h00000000, 64'h1_8000_0044, eIll, eIll);
    waitDrain();
    checkOutput("cnt32_inc2", {48'h0, illCnt32}, 64'd6);
    checkOutput("cnt64_sat", {62'h0, illCnt64}, 64'd3);

    // Stall with three back-to-back inputs, then release
    outReady = 1'b0;
    presentCycle(32'h7FF00093, 64'h1_8000_0050, mk(64'h7FF, 3'd1, 1'b0), mk(64'h7FF, 3'd1, 1'b0), acc);
    checkOutput("skid_accA", {63'h0, acc}, 64'h1);
    presentCycle(32'h00208463, 64'h1_8000_0054, mk(64'h8, 3'd3, 1'b0), mk(64'h8, 3'd3, 1'b0), acc);
    checkOutput("skid_accB", {63'h0, acc}, 64'h1);
    presentCycle(32'h12345017, 64'h1_8000_0058, mk(64'h1234_5000, 3'd4, 1'b0),
                 mk(64'h1234_5000, 3'd4, 1'b0), acc);
    checkOutput("skid_holdC1", {63'h0, acc}, 64'h0);
    presentCycle(32'h12345017, 64'h1_8000_0058, mk(64'h1234_5000, 3'd4, 1'b0),
                 mk(64'h1234_5000, 3'd4, 1'b0), acc);
    checkOutput("skid_holdC2", {63'h0, acc}, 64'h0);
    checkOutput("skid_ready64", {63'h0, inReady64}, 64'h0);
    @(posedge clk);
    #1;
    outReady = 1'b1;
    base32 = hs32;
    base64 = hs64;
    @(negedge clk);
    #1;
    checkOutput("skid_ready_drain", {63'h0, inReady32}, 64'h0);
    presentCycle(32'h12345017, 64'h1_8000_0058, mk(64'h1234_5000, 3'd4, 1'b0),
                 mk(64'h1234_5000, 3'd4, 1'b0), acc);
    checkOutput("skid_accC", {63'h0, acc}, 64'h1);
    idle();
    @(negedge clk);
    #1;
    checkOutput("rate32", hs32 - base32, 64'd3);
    checkOutput("rate64", hs64 - base64, 64'd3);
    waitDrain();

    // Flush with both entries full and out_ready low
    outReady = 1'b0;
    applyStimulus(32'hFFC12083, 64'h1_8000_0060, mk(64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0),
                  mk(64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0));
    applyStimulus(32'h00000000, 64'h1_8000_0064, eIll, eIll);
    @(posedge clk);
    #1;
    flush = 1'b1;
    inValid = 1'b1;
    inInst = 32'h7FF00093;
    @(negedge clk);
    q32.delete();
    q64.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
    inValid = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("flush_valid32", {63'h0, outValid32}, 64'h0);
    checkOutput("flush_valid64", {63'h0, outValid64}, 64'h0);
    checkOutput("flush_ready32", {63'h0, inReady32}, 64'h1);
    checkOutput("flush_cnt32", {48'h0, illCnt32}, 64'd6);
    checkOutput("flush_cnt64", {62'h0, illCnt64}, 64'd3);

    // Flush beats a pending handshake and discards the input presented with it
    outReady = 1'b1;
    applyStimulus(32'h00000000, 64'h1_8000_0070, eIll, eIll);
    @(posedge clk);
    #1;
    flush = 1'b1;
    inInst = 32'h7FF00093;
    @(negedge clk);
    q32.delete();
    q64.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
    inValid = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("flush2_valid32", {63'h0, outValid32}, 64'h0);
    checkOutput("flush2_cnt32", {48'h0, illCnt32}, 64'd6);

    // Asynchronous reset in the middle of a stall
    outReady = 1'b0;
    applyStimulus(32'hFE112E23, 64'h1_8000_0080, mk(64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0),
                  mk(64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0));
    applyStimulus(32'h00000000, 64'h1_8000_0084, eIll, eIll);
    idle();
    @(negedge clk);
    #1;
    checkOutput("stall_ready", {63'h0, inReady32}, 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_valid32", {63'h0, outValid32}, 64'h0);
    checkOutput("mid_valid64", {63'h0, outValid64}, 64'h0);
    checkOutput("mid_imm32", {32'h0, outImm32}, 64'h0);
    checkOutput("mid_fmt64", {61'h0, outFmt64}, 64'h0);
    checkOutput("mid_ill64", {63'h0, outIllegal64}, 64'h0);
    checkOutput("mid_pc64", outPc64, 64'h0);
    checkOutput("mid_cnt32", {48'h0, illCnt32}, 64'h0);
    checkOutput("mid_cnt64", {62'h0, illCnt64}, 64'h0);
    q32.delete();
    q64.delete();
    outReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_ready_before", {63'h0, inReady32}, 64'h0);
    @(posedge clk);
    #1;
    checkOutput("rel_ready_after", {63'h0, inReady32}, 64'h1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("post_rst_valid32", {63'h0, outValid32}, 64'h0);
    checkOutput("post_rst_valid64", {63'h0, outValid64}, 64'h0);

    // Normal operation after reset
    applyStimulus(32'h0010006F, 64'h1_8000_0090, mk(64'h800, 3'd5, 1'b0), mk(64'h800, 3'd5, 1'b0));
    waitDrain();
    checkOutput("final_cnt32", {48'h0, illCnt32}, 64'h0);
    checkOutput("q32_empty", 64'(q32.size()), 64'h0);
    checkOutput("q64_empty", 64'(q64.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
